uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- Serial debug and loader initiator: the other end of the memory-mapped UART.
- Receives 8N1 command frames on rxd and executes them as 16-bit bus master cycles on the system bus.
- Returns responses on txd.
- Acquires the bus through a bus_req/bus_gnt handshake with the CPU/arbiter; used for host download and memory peek/poke.

Parameters:
- CLKSPEED, 32000000, main clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIVISOR, CLKSPEED/BAUD, clken cycles per bit time.
- TIMEOUT_BITS, 1024, idle bit times allowed between bytes of one command before abort.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- clken  in  1  clock enable; all state advances only when high.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- txd  out  1  serial output, idle high.
- bus_req  out  1  bus request to arbiter.
- bus_gnt  in  1  bus grant from arbiter.
- addr  out  16  bus address.
- dout  out  16  write data.
- din  in  16  read data.
- rnw  out  1  1 = read, 0 = write.
- cs_b  out  1  active-low bus strobe.

Behaviour:
- Reset values (asynchronous, on reset_b low): txd=1, bus_req=0, cs_b=1, rnw=1, addr=0, dout=0. FSM=IDLE, RX/TX idle, holding register empty. Reset mid-operation aborts everything immediately, including a bus cycle in progress or a byte being sent.
- Receiver:
  - rxd passes through 2 sync flops; a falling edge of the synced signal starts a frame.
  - Start bit re-checked at DIVISOR/2; data bits sampled every DIVISOR thereafter, LSB first.
  - Stop bit must be 1, otherwise framing error: byte discarded, no other effect.
  - Good byte goes to a 1-byte holding register. If the register is still full when a new byte completes, the new byte is dropped.
- Transmitter: 8N1, LSB first, DIVISOR cycles per bit, start bit 0, stop bit 1. Accepts a byte only when idle.
- Command protocol (big-endian fields):
  - 'W'(0x57) AH AL DH DL: write DH:DL to AH:AL, then send 0x2E ('.').
  - 'R'(0x52) AH AL: read AH:AL, then send DH then DL.
  - Any other first byte: send 0x3F ('?'), return to IDLE.
- FSM states and transitions:
  - IDLE -> GET_AH -> GET_AL -> [GET_DH -> GET_DL, write only] -> REQ -> ACCESS -> RESP -> IDLE.
  - GET_* states consume one byte each from the holding register.
  - Timeout: TIMEOUT_BITS*DIVISOR clken cycles with no byte while in any GET_* state -> IDLE, silently. The counter reloads on every accepted byte.
  - Holding register is not consumed in REQ, ACCESS or RESP. A byte arriving then is held and becomes the next command byte.
- Bus cycle:
  - REQ: bus_req=1; addr, dout and rnw are driven from that point on. Wait indefinitely for bus_gnt=1, sampled on clken.
  - ACCESS: cs_b=0 for exactly one clken cycle. For reads, din is captured on the clken edge that ends ACCESS.
  - On exit from ACCESS, cs_b=1 and bus_req=0. addr, dout and rnw hold their values until the next REQ.
  - bus_gnt dropping during REQ is ignored (keep waiting). Grant is not re-checked during ACCESS.
- RESP: queue 1 byte (write, unknown) or 2 bytes (read). Wait for TX idle before each byte. No gap beyond one clken cycle between consecutive response bytes.
- Full duplex: reception continues while RESP is transmitting.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - command codes CMD_WRITE=0x57, CMD_READ=0x52;
  - response codes RSP_ACK=0x2E, RSP_ERR=0x3F;
  - FSM state enum;
  - bit-count widths derived from DIVISOR and TIMEOUT_BITS.
- One sub-module, uart_rx_byte: synchroniser, start detect, sampling, framing check. Outputs a byte plus a one-cycle valid strobe.
- TX serializer and command FSM stay in the top module.

Test Plan:
- Write path: serial 57 12 34 AB CD, bus_gnt tied 1 -> one cs_b=0 cycle with addr=0x1234, dout=0xABCD, rnw=0; then txd frame 0x2E.
- Read path: serial 52 00 40 with din=0xBEEF during ACCESS -> one cs_b=0 cycle with rnw=1, addr=0x0040; txd sends 0xBE then 0xEF.
- Grant stall: bus_gnt held 0 for 500 cycles after a read command -> bus_req=1 and cs_b=1 throughout; cs_b pulses only after bus_gnt rises; response follows.
- Error cases:
  - Unknown byte 0x41 -> txd 0x3F, no bus_req.
  - Frame with stop bit 0 -> no response, FSM stays IDLE.
- Timeout: send 57 12 then silence for TIMEOUT_BITS+1 bit times, then 52 00 01 -> no write cycle; read of 0x0001 executes normally.
- Reset mid-op: assert reset_b low during ACCESS and again mid-txd-byte -> cs_b=1, bus_req=0, txd=1 immediately (asynchronous); next command after release works.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared constants, state encodings and counter-width helper for the UART bus bridge.
// No logic of its own; every bridge file imports it.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h2E;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  localparam int DEF_CLKSPEED     = 32000000;
  localparam int DEF_BAUD         = 115200;
  localparam int DEF_DIVISOR      = DEF_CLKSPEED / DEF_BAUD;
  localparam int DEF_TIMEOUT_BITS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL, ST_REQ, ST_ACCESS, ST_RESP
  } state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bits needed for a down-counter that starts at n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// System-bus side of the bridge: request/grant handshake plus a 16-bit single-strobe cycle.
// Master drives the cycle; slave (arbiter + memory) supplies grant and read data.
interface uart_bus_bridge_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] addr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        rnw;
  logic        cs_b;

  modport master (output bus_req, addr, dout, rnw, cs_b, input bus_gnt, din);
  modport slave  (input bus_req, addr, dout, rnw, cs_b, output bus_gnt, din);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, framing check; rx_vld strobes one clken cycle.
// Latency ~9.5 bit times from start edge; no backpressure, the consumer must take rx_dat on the strobe.
module uart_rx_byte
  import uart_bridge_pkg::*;
#(
  parameter int DIVISOR = DEF_DIVISOR
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       clken,
  input  logic       rxd,
  output logic [7:0] rx_dat,
  output logic       rx_vld
);

  localparam int DIV_W = cnt_w(DIVISOR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIVISOR / 2 - 1);

  rx_state_t        state, state_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             tick, fall;

  assign tick = (cnt == '0);
  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else if (clken) begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)   state <= RX_IDLE;
    else if (clken) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      // A glitch shorter than half a bit is not a start bit.
      RX_START: if (tick) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (tick) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt     <= '0;
      bit_idx <= '0;
      rx_dat  <= '0;
      rx_vld  <= 1'b0;
    end else if (clken) begin
      rx_vld <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= DIV_HALF;
          bit_idx <= '0;
        end
        RX_START: cnt <= tick ? DIV_LAST : cnt - 1'b1;
        RX_DATA: begin
          if (tick) begin
            rx_dat  <= {rx_sync, rx_dat[7:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= DIV_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (tick) rx_vld <= rx_sync;
          else      cnt    <= cnt - 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial command initiator: 'W' AH AL DH DL / 'R' AH AL frames become 16-bit bus cycles, answered on txd.
// One-byte holding register, later bytes dropped while full; bus REQ waits on bus_gnt indefinitely.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKSPEED     = DEF_CLKSPEED,
  parameter int BAUD         = DEF_BAUD,
  parameter int DIVISOR      = CLKSPEED / BAUD,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clken,
  input  logic rxd,
  output logic txd,
  uart_bus_bridge_if.master bus
);

  localparam int DIV_W = cnt_w(DIVISOR);
  localparam int TMO_W = cnt_w(TIMEOUT_BITS * DIVISOR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_BITS * DIVISOR - 1);

  state_t           state, state_nxt;
  logic [7:0]       rx_dat, hold_dat;
  logic             rx_vld, hold_full, hold_take;
  logic [TMO_W-1:0] tmo_cnt;
  logic             is_get, tmo_hit, is_wr;
  logic [15:0]      cmd_addr, cmd_data, addr_r, dout_r, resp_buf;
  logic             rnw_r;
  logic [1:0]       resp_left;
  logic             tx_load, tx_busy;
  logic [8:0]       tx_sr;
  logic [3:0]       tx_bits;
  logic [DIV_W-1:0] tx_div;

  uart_rx_byte #(.DIVISOR(DIVISOR)) u_rx (
    .clk     (clk),
    .reset_b (reset_b),
    .clken   (clken),
    .rxd     (rxd),
    .rx_dat  (rx_dat),
    .rx_vld  (rx_vld)
  );

  assign is_get  = (state == ST_GET_AH) || (state == ST_GET_AL) ||
                   (state == ST_GET_DH) || (state == ST_GET_DL);
  assign tmo_hit = (tmo_cnt == '0);

  assign bus.bus_req = (state == ST_REQ) || (state == ST_ACCESS);
  assign bus.cs_b    = (state != ST_ACCESS);
  assign bus.addr    = addr_r;
  assign bus.dout    = dout_r;
  assign bus.rnw     = rnw_r;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)   state <= ST_IDLE;
    else if (clken) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hold_take = 1'b0;
    tx_load   = 1'b0;
    case (state)
      ST_IDLE: if (hold_full) begin
        hold_take = 1'b1;
        state_nxt = (hold_dat == CMD_WRITE || hold_dat == CMD_READ) ? ST_GET_AH : ST_RESP;
      end
      ST_GET_AH: if (hold_full) begin
        hold_take = 1'b1;
        state_nxt = ST_GET_AL;
      end else if (tmo_hit) state_nxt = ST_IDLE;
      ST_GET_AL: if (hold_full) begin
        hold_take = 1'b1;
        state_nxt = is_wr ? ST_GET_DH : ST_REQ;
      end else if (tmo_hit) state_nxt = ST_IDLE;
      ST_GET_DH: if (hold_full) begin
        hold_take = 1'b1;
        state_nxt = ST_GET_DL;
      end else if (tmo_hit) state_nxt = ST_IDLE;
      ST_GET_DL: if (hold_full) begin
        hold_take = 1'b1;
        state_nxt = ST_REQ;
      end else if (tmo_hit) state_nxt = ST_IDLE;
      ST_REQ:    if (bus.bus_gnt) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        if (resp_left == 2'd0) state_nxt = ST_IDLE;
        else if (!tx_busy)     tx_load   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
      tmo_cnt   <= TMO_LAST;
      is_wr     <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      addr_r    <= '0;
      dout_r    <= '0;
      rnw_r     <= 1'b1;
      resp_buf  <= '0;
      resp_left <= '0;
    end else if (clken) begin
      if (hold_take)                  hold_full <= 1'b0;
      else if (rx_vld && !hold_full) begin
        hold_full <= 1'b1;
        hold_dat  <= rx_dat;
      end

      if (hold_take)               tmo_cnt <= TMO_LAST;
      else if (is_get && !tmo_hit) tmo_cnt <= tmo_cnt - 1'b1;

      // The last field byte goes straight to the bus registers so they are valid in REQ.
      if (hold_take) begin
        case (state)
          ST_IDLE: begin
            is_wr     <= (hold_dat == CMD_WRITE);
            resp_buf  <= {RSP_ERR, 8'h00};
            resp_left <= 2'd1;
          end
          ST_GET_AH: cmd_addr[15:8] <= hold_dat;
          ST_GET_AL: begin
            cmd_addr[7:0] <= hold_dat;
            if (!is_wr) begin
              addr_r <= {cmd_addr[15:8], hold_dat};
              rnw_r  <= 1'b1;
            end
          end
          ST_GET_DH: cmd_data[15:8] <= hold_dat;
          ST_GET_DL: begin
            addr_r <= cmd_addr;
            dout_r <= {cmd_data[15:8], hold_dat};
            rnw_r  <= 1'b0;
          end
          default: ;
        endcase
      end

      if (state == ST_ACCESS) begin
        resp_buf  <= is_wr ? {RSP_ACK, 8'h00} : bus.din;
        resp_left <= is_wr ? 2'd1 : 2'd2;
      end

      if (tx_load) begin
        resp_buf  <= {resp_buf[7:0], 8'h00};
        resp_left <= resp_left - 1'b1;
      end
    end
  end

  // tx_sr holds {stop, data}; the start bit is driven directly on load.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      txd     <= 1'b1;
      tx_busy <= 1'b0;
      tx_sr   <= '0;
      tx_bits <= '0;
      tx_div  <= '0;
    end else if (clken) begin
      if (tx_load) begin
        tx_sr   <= {1'b1, resp_buf[15:8]};
        txd     <= 1'b0;
        tx_busy <= 1'b1;
        tx_bits <= 4'd9;
        tx_div  <= DIV_LAST;
      end else if (tx_busy) begin
        if (tx_div == '0) begin
          tx_div <= DIV_LAST;
          if (tx_bits == 4'd0) begin
            tx_busy <= 1'b0;
          end else begin
            txd     <= tx_sr[0];
            tx_sr   <= {1'b1, tx_sr[8:1]};
            tx_bits <= tx_bits - 1'b1;
          end
        end else begin
          tx_div <= tx_div - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: drives serial commands, decodes txd, watches the bus.
module tb_uart_bus_bridge;

  localparam int D  = 8;
  localparam int TB = 16;

  logic clk     = 1'b0;
  logic reset_b = 1'b0;
  logic clken   = 1'b1;
  logic rxd     = 1'b1;
  logic txd;

  uart_bus_bridge_if bus ();

  uart_bus_bridge #(
    .CLKSPEED     (800),
    .BAUD         (100),
    .DIVISOR      (D),
    .TIMEOUT_BITS (TB)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .clken   (clken),
    .rxd     (rxd),
    .txd     (txd),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // txd decoder: each entry is {stop_bit, data}.
  logic [8:0] rsp_q[$];
  initial begin : tx_mon
    logic [8:0] f;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        repeat (D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          f[i] = txd;
        end
        repeat (D) @(negedge clk);
        f[8] = txd;
        rsp_q.push_back(f);
      end
    end
  end

  int          cs_cnt  = 0;
  int          wr_cnt  = 0;
  int          req_cnt = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_dout = '0;
  logic        last_rnw  = 1'b1;

  always @(negedge clk) begin
    if (bus.cs_b === 1'b0) begin
      cs_cnt++;
      if (bus.rnw === 1'b0) wr_cnt++;
      last_addr = bus.addr;
      last_dout = bus.dout;
      last_rnw  = bus.rnw;
    end
    if (bus.bus_req === 1'b1) req_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (D) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (D) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int t = 0;
    while (rsp_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, rsp_q.size(), n);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    logic [8:0] v;
    v = (rsp_q.size() > 0) ? rsp_q.pop_front() : 9'h000;
    check(tag, v, {1'b1, exp});
  endtask

  task automatic wait_req(input string tag);
    int t = 0;
    while (bus.bus_req !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, bus.bus_req, 1);
  endtask

  task automatic wait_txd(input logic lvl, input string tag);
    int t = 0;
    while (txd !== lvl && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, txd, lvl);
  endtask

  initial begin : main
    int c0, w0, r0, bad;
    bus.bus_gnt = 1'b1;
    bus.din     = 16'hBEEF;

    repeat (3) @(negedge clk);
    check("rst_txd",     txd,         1);
    check("rst_bus_req", bus.bus_req, 0);
    check("rst_cs_b",    bus.cs_b,    1);
    check("rst_rnw",     bus.rnw,     1);
    check("rst_addr",    bus.addr,    0);
    check("rst_dout",    bus.dout,    0);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xABCD to 0x1234.
    c0 = cs_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    wait_rsp(1, "wr_rsp_cnt");
    pop_chk("wr_rsp", 8'h2E);
    check("wr_cs_pulses", cs_cnt - c0, 1);
    check("wr_addr", last_addr, 16'h1234);
    check("wr_dout", last_dout, 16'hABCD);
    check("wr_rnw",  last_rnw,  0);
    check("wr_req_released", bus.bus_req, 0);

    // Read 0x0040, din = 0xBEEF.
    c0 = cs_cnt;
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1);
    wait_rsp(2, "rd_rsp_cnt");
    pop_chk("rd_rsp_hi", 8'hBE);
    pop_chk("rd_rsp_lo", 8'hEF);
    check("rd_cs_pulses", cs_cnt - c0, 1);
    check("rd_addr", last_addr, 16'h0040);
    check("rd_rnw",  last_rnw,  1);

    // Grant withheld for 500 cycles.
    bus.bus_gnt = 1'b0;
    bus.din     = 16'h1357;
    c0 = cs_cnt;
    send_byte(8'h52, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h00, 1'b1);
    wait_req("stall_req");
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.bus_req !== 1'b1 || bus.cs_b !== 1'b1) bad++;
    end
    check("stall_hold", bad, 0);
    check("stall_no_cs", cs_cnt - c0, 0);
    bus.bus_gnt = 1'b1;
    wait_rsp(2, "stall_rsp_cnt");
    pop_chk("stall_rsp_hi", 8'h13);
    pop_chk("stall_rsp_lo", 8'h57);
    check("stall_cs_pulses", cs_cnt - c0, 1);
    check("stall_addr", last_addr, 16'h1200);

    // Unknown command byte.
    r0 = req_cnt;
    send_byte(8'h41, 1'b1);
    wait_rsp(1, "unk_rsp_cnt");
    pop_chk("unk_rsp", 8'h3F);
    check("unk_no_req", req_cnt - r0, 0);

    // Framing error: a 'W' with a bad stop bit must leave the FSM idle.
    send_byte(8'h57, 1'b0);
    repeat (4 * D) @(negedge clk);
    check("frm_silent", rsp_q.size(), 0);
    r0 = req_cnt;
    send_byte(8'h41, 1'b1);
    wait_rsp(1, "frm_next_cnt");
    pop_chk("frm_next_rsp", 8'h3F);
    check("frm_no_req", req_cnt - r0, 0);

    // Timeout: partial write abandoned, following read runs normally.
    bus.din = 16'hA55A;
    c0 = cs_cnt;
    w0 = wr_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1);
    repeat ((TB + 1) * D) @(negedge clk);
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    wait_rsp(2, "tmo_rsp_cnt");
    pop_chk("tmo_rsp_hi", 8'hA5);
    pop_chk("tmo_rsp_lo", 8'h5A);
    check("tmo_no_write", wr_cnt - w0, 0);
    check("tmo_cs_pulses", cs_cnt - c0, 1);
    check("tmo_addr", last_addr, 16'h0001);

    // Reset while cs_b is asserted.
    bus.bus_gnt = 1'b0;
    send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    wait_req("racc_req");
    @(negedge clk);
    bus.bus_gnt = 1'b1;
    @(posedge clk);
    #2;
    check("racc_in_access", bus.cs_b, 0);
    reset_b = 1'b0;
    #1;
    check("racc_cs_b",    bus.cs_b,    1);
    check("racc_bus_req", bus.bus_req, 0);
    check("racc_txd",     txd,         1);
    check("racc_addr",    bus.addr,    0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (4 * D) @(negedge clk);
    check("racc_no_rsp", rsp_q.size(), 0);

    // Reset in the middle of a response byte (0x3F: data bit 6 is low).
    send_byte(8'h41, 1'b1);
    wait_txd(1'b0, "rtx_start");
    wait_txd(1'b1, "rtx_d0");
    wait_txd(1'b0, "rtx_d6");
    reset_b = 1'b0;
    #1;
    check("rtx_txd",     txd,         1);
    check("rtx_bus_req", bus.bus_req, 0);
    check("rtx_cs_b",    bus.cs_b,    1);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (12 * D) @(negedge clk);
    rsp_q.delete();

    // Bridge is fully usable after the resets.
    c0 = cs_cnt;
    send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    wait_rsp(1, "post_rsp_cnt");
    pop_chk("post_rsp", 8'h2E);
    check("post_cs_pulses", cs_cnt - c0, 1);
    check("post_addr", last_addr, 16'h0010);
    check("post_dout", last_dout, 16'h55AA);
    check("post_rnw",  last_rnw,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
